// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: decode-stage hazard detection for an in-order RV32I pipe.
// Tracks DEPTH downstream stages in a shift-register scoreboard, picks
// forwarding sources for rs1/rs2, stalls on load-use, and holds flush for
// FLUSH_CYCLES cycles after a taken control transfer.
// Ports:
//   clk, rst          clock (rising), async active-high reset
//   instr_id          instruction in decode; instr_valid qualifies it
//   br_taken          taken branch/JAL/JALR resolved this cycle
//   stall, flush      hold PC/decode; squash decode
//   fwd_sel_a/b       0 = register file, k = scoreboard stage k
//   stall_cnt/flush_cnt  saturating perf counters

// One scoreboard entry's source comparison.
module pipeline_hazard_match (
  input  logic       vld,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  output logic       hit_a,
  output logic       hit_b
);
  assign hit_a = vld & use_rs1 & (rd == rs1);
  assign hit_b = vld & use_rs2 & (rd == rs2);
endmodule

module pipeline_hazard_unit #(
  parameter int DEPTH        = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_id,
  input  logic             instr_valid,
  input  logic             br_taken,
  output logic             stall,
  output logic             flush,
  output logic [2:0]       fwd_sel_a,
  output logic [2:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       ld;
  } sb_ent_t;

  sb_ent_t [DEPTH:1] sb;
  logic [2:0]        fcnt;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic       use_rd, use_rs1, use_rs2, is_ld;
  logic       issue;
  logic       unused_ok;

  assign opc = instr_id[6:0];
  assign rd  = instr_id[11:7];
  assign rs1 = instr_id[19:15];
  assign rs2 = instr_id[24:20];
  assign unused_ok = ^{instr_id[31:25], instr_id[14:12]};

  always_comb begin
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_ld   = 1'b0;
    case (opc)
      7'b0110011: begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0010011: begin use_rd = 1'b1; use_rs1 = 1'b1; end
      7'b0000011: begin use_rd = 1'b1; use_rs1 = 1'b1; is_ld = 1'b1; end
      7'b0110111,
      7'b0010111,
      7'b1101111: use_rd = 1'b1;
      7'b1100111: begin use_rd = 1'b1; use_rs1 = 1'b1; end
      7'b0100011,
      7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default: ;
    endcase
  end

  logic [DEPTH:1] hit_a, hit_b;

  for (genvar g = 1; g <= DEPTH; g++) begin : g_match
    pipeline_hazard_match u_match (
      .vld    (sb[g].vld),
      .rd     (sb[g].rd),
      .rs1    (rs1),
      .rs2    (rs2),
      .use_rs1(use_rs1),
      .use_rs2(use_rs2),
      .hit_a  (hit_a[g]),
      .hit_b  (hit_b[g])
    );
  end

  // Youngest match wins: scan oldest to youngest so the last write is lowest k.
  logic [2:0] sel_a, sel_b;
  logic       ld_a, ld_b;
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit_a[k]) begin
        sel_a = 3'(k);
        ld_a  = sb[k].ld && (k <= LOAD_LAT);
      end
      if (hit_b[k]) begin
        sel_b = 3'(k);
        ld_b  = sb[k].ld && (k <= LOAD_LAT);
      end
    end
  end

  // br_taken is combinational into flush, so gate with rst to keep flush low
  // while reset is held.
  assign flush     = ~rst & (br_taken | (fcnt != '0));
  assign stall     = instr_valid & ~flush & (ld_a | ld_b);
  assign fwd_sel_a = flush ? '0 : sel_a;
  assign fwd_sel_b = flush ? '0 : sel_b;
  assign issue     = instr_valid & ~stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb[1].vld <= issue & use_rd & (rd != 5'd0);
      sb[1].rd  <= issue ? rd : 5'd0;
      sb[1].ld  <= issue & is_ld;
      for (int k = 2; k <= DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  // fcnt holds the flush cycles remaining after the current one; a new
  // br_taken restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                fcnt <= '0;
    else if (br_taken)      fcnt <= 3'(FLUSH_CYCLES - 1);
    else if (fcnt != '0)    fcnt <= fcnt - 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule
